// File: rtl/accel_pkg.sv
// Shared types and register bit positions for the dot-product sequencer.
// The MAC block and the sequencer top import this package.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int START_BIT = 0;
  localparam int ABORT_BIT = 1;
  localparam int LEN_LSB   = 8;
  localparam int LEN_MSB   = 15;

  localparam int DONE_BIT  = 0;
  localparam int BUSY_BIT  = 1;
  localparam int OVF_BIT   = 2;

  localparam int ADDR_STEP_DEF = 4;

  // Signed-add overflow: both addends share a sign that the sum does not.
  function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] s);
    return (x[31] == y[31]) && (s[31] != x[31]);
  endfunction

endpackage

// File: rtl/accel_mac16.sv
// Signed 16x16 multiply with a wrapping 32-bit accumulator and a sticky overflow flag.
// Clear has priority over enable.
module accel_mac16 import accel_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_acc,
  output logic        o_ovf
);

  logic signed [31:0] w_prod;
  logic        [31:0] w_sum;
  logic        [31:0] r_acc;
  logic               r_ovf;

  assign w_prod = $signed(i_a) * $signed(i_b);
  assign w_sum  = r_acc + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_sum;
      if (add_ovf(r_acc, w_prod, w_sum)) r_ovf <= 1'b1;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/accel_dot_seq.sv
// Dot-product sequencer: reads vectors A and B from SRAM, accumulates a*b,
// writes the sum just past the end of B and raises a sticky done flag.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// RD_A  | read A[idx]
// RD_B  | read B[idx], capture A[idx]
// MAC   | accumulate A[idx]*B[idx], advance idx
// WR    | write acc to b_base + len*step, latch result
// DONE  | one cycle, done already set, back to IDLE
module accel_dot_seq import accel_pkg::*; #(
  parameter int              ADDR_W    = 13,
  parameter int              DATA_W    = 32,
  parameter int              ADDR_STEP = ADDR_STEP_DEF,
  parameter logic [ADDR_W-1:0] A_BASE  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       stat_reg_cal,
  input  logic [15:0]       ram_sel,
  output logic [15:0]       done_reg,
  output logic              seq_rd_en,
  output logic [ADDR_W-1:0] seq_rd_addr,
  input  logic [DATA_W-1:0] seq_rd_data,
  output logic              seq_wr_en,
  output logic [ADDR_W-1:0] seq_wr_addr,
  output logic [DATA_W-1:0] seq_wr_data,
  output logic [31:0]       result
);

  state_t            r_state, w_next;
  logic              r_start_d;
  logic [7:0]        r_len;
  logic [ADDR_W-1:0] r_b_base;
  logic [7:0]        r_idx;
  logic [15:0]       r_a;
  logic              r_done;
  logic [31:0]       r_result;

  logic              w_start_pulse;
  logic              w_busy;
  logic              w_abort;
  logic              w_capture;
  logic              w_mac_en;
  logic              w_wr_fire;
  logic [7:0]        w_len_in;
  logic [8:0]        w_idx_nxt;
  logic [ADDR_W-1:0] w_idx_off;
  logic [ADDR_W-1:0] w_len_off;
  logic [31:0]       w_acc;
  logic              w_ovf;
  logic              w_unused;

  assign w_start_pulse = stat_reg_cal[START_BIT] & ~r_start_d;
  assign w_len_in      = stat_reg_cal[LEN_MSB:LEN_LSB];
  assign w_busy        = (r_state == RD_A) || (r_state == RD_B) ||
                         (r_state == MAC)  || (r_state == WR);
  assign w_abort       = stat_reg_cal[ABORT_BIT] & w_busy;
  assign w_capture     = (r_state == IDLE) & w_start_pulse;
  assign w_idx_nxt     = {1'b0, r_idx} + 9'd1;
  assign w_idx_off     = ADDR_W'(r_idx) * ADDR_W'(ADDR_STEP);
  assign w_len_off     = ADDR_W'(r_len) * ADDR_W'(ADDR_STEP);
  assign w_unused      = ^{ram_sel[15:ADDR_W], seq_rd_data[DATA_W-1:16],
                           stat_reg_cal[LEN_LSB-1:ABORT_BIT+1]};

  accel_mac16 u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_capture),
    .i_en  (w_mac_en),
    .i_a   (r_a),
    .i_b   (seq_rd_data[15:0]),
    .o_acc (w_acc),
    .o_ovf (w_ovf)
  );

  always_comb begin
    w_next      = r_state;
    seq_rd_en   = 1'b0;
    seq_rd_addr = '0;
    seq_wr_en   = 1'b0;
    seq_wr_addr = '0;
    seq_wr_data = '0;
    w_mac_en    = 1'b0;
    case (r_state)
      IDLE: if (w_start_pulse) w_next = (w_len_in == 8'd0) ? WR : RD_A;
      RD_A: begin
        seq_rd_en   = 1'b1;
        seq_rd_addr = A_BASE + w_idx_off;
        w_next      = RD_B;
      end
      RD_B: begin
        seq_rd_en   = 1'b1;
        seq_rd_addr = r_b_base + w_idx_off;
        w_next      = MAC;
      end
      MAC: begin
        w_mac_en = 1'b1;
        w_next   = (w_idx_nxt < {1'b0, r_len}) ? RD_A : WR;
      end
      WR: begin
        seq_wr_en   = 1'b1;
        seq_wr_addr = r_b_base + w_len_off;
        seq_wr_data = DATA_W'(w_acc);
        w_next      = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Abort wins over whatever this cycle would have done.
    if (w_abort) begin
      w_next      = IDLE;
      seq_rd_en   = 1'b0;
      seq_rd_addr = '0;
      seq_wr_en   = 1'b0;
      seq_wr_addr = '0;
      seq_wr_data = '0;
      w_mac_en    = 1'b0;
    end
  end

  assign w_wr_fire = (r_state == WR) & ~w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_d <= 1'b0;
      r_len     <= '0;
      r_b_base  <= '0;
      r_idx     <= '0;
      r_a       <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state   <= w_next;
      r_start_d <= stat_reg_cal[START_BIT];
      if (w_capture) begin
        r_len    <= w_len_in;
        r_b_base <= ram_sel[ADDR_W-1:0];
        r_idx    <= '0;
        r_done   <= 1'b0;
        r_result <= '0;
      end
      if (r_state == RD_B) r_a <= seq_rd_data[15:0];
      if (w_mac_en) r_idx <= r_idx + 8'd1;
      if (w_wr_fire) begin
        r_result <= w_acc;
        r_done   <= 1'b1;
      end
    end
  end

  always_comb begin
    done_reg           = '0;
    done_reg[DONE_BIT] = r_done;
    done_reg[BUSY_BIT] = w_busy;
    done_reg[OVF_BIT]  = w_ovf;
  end

  assign result = r_result;

endmodule

// File: tb/tb_accel_dot_seq.sv
// Directed bench for accel_dot_seq with a one-cycle-latency SRAM model.
module tb_accel_dot_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] stat_reg_cal;
  logic [15:0] ram_sel;
  logic [15:0] done_reg;
  logic        seq_rd_en;
  logic [12:0] seq_rd_addr;
  logic [31:0] seq_rd_data;
  logic        seq_wr_en;
  logic [12:0] seq_wr_addr;
  logic [31:0] seq_wr_data;
  logic [31:0] result;

  logic [31:0] mem [0:2047];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          viol   = 0;
  logic [12:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  accel_dot_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stat_reg_cal (stat_reg_cal),
    .ram_sel      (ram_sel),
    .done_reg     (done_reg),
    .seq_rd_en    (seq_rd_en),
    .seq_rd_addr  (seq_rd_addr),
    .seq_rd_data  (seq_rd_data),
    .seq_wr_en    (seq_wr_en),
    .seq_wr_addr  (seq_wr_addr),
    .seq_wr_data  (seq_wr_data),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) seq_rd_data <= mem[seq_rd_addr[12:2]];

  always @(posedge clk) begin
    if (seq_wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= seq_wr_addr;
      last_wr_data <= seq_wr_data;
    end
    if (seq_rd_en) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    if ((seq_rd_en && seq_wr_en) ||
        (!seq_rd_en && seq_rd_addr != 13'd0) ||
        (!seq_wr_en && (seq_wr_addr != 13'd0 || seq_wr_data != 32'd0)))
      viol <= viol + 1;
  end

  task automatic run_dot(input string nm, input logic [7:0] len, input logic [15:0] rs,
                         input logic [12:0] exp_addr, input logic [31:0] exp_data,
                         input logic [15:0] exp_done, input int exp_rd);
    int w0, r0;
    @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    ram_sel = rs;
    stat_reg_cal = {len, 8'h01};
    @(negedge clk);
    n_cmp++;
    if (done_reg !== 16'h0002) begin n_err++; $display("FAIL %s_busy_start: got %h want 0002", nm, done_reg); end
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL %s_result_clr: got %h want 0", nm, result); end
    repeat (3 * int'(len)) @(negedge clk);
    n_cmp++;
    if (done_reg !== ((exp_done & 16'h0004) | 16'h0002) || seq_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL %s_wr_cycle: got done_reg %h wr_en %b want %h 1", nm, done_reg, seq_wr_en,
               (exp_done & 16'h0004) | 16'h0002);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL %s_wr_count: got %0d want 1", nm, wr_cnt - w0); end
    n_cmp++;
    if (last_wr_addr !== exp_addr) begin n_err++; $display("FAIL %s_wr_addr: got %h want %h", nm, last_wr_addr, exp_addr); end
    n_cmp++;
    if (last_wr_data !== exp_data) begin n_err++; $display("FAIL %s_wr_data: got %h want %h", nm, last_wr_data, exp_data); end
    n_cmp++;
    if (result !== exp_data) begin n_err++; $display("FAIL %s_result: got %h want %h", nm, result, exp_data); end
    n_cmp++;
    if (done_reg !== exp_done) begin n_err++; $display("FAIL %s_done_reg: got %h want %h", nm, done_reg, exp_done); end
    n_cmp++;
    if (rd_cnt - r0 !== exp_rd) begin n_err++; $display("FAIL %s_rd_count: got %0d want %0d", nm, rd_cnt - r0, exp_rd); end
    stat_reg_cal = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stat_reg_cal = 16'h0; ram_sel = 16'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_reg !== 16'h0 || result !== 32'h0 || seq_rd_en !== 1'b0 || seq_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got done_reg %h result %h rd %b wr %b want all 0", done_reg, result, seq_rd_en, seq_wr_en);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    mem[0] = 32'hABCD_0001; mem[1] = 32'hABCD_0002; mem[2] = 32'hABCD_0003;
    mem[13'h100 >> 2] = 32'h1234_0004; mem[(13'h100 >> 2) + 1] = 32'h1234_0005;
    mem[(13'h100 >> 2) + 2] = 32'h1234_0006;
    run_dot("basic", 8'd3, 16'h0100, 13'h10C, 32'h0000_0020, 16'h0001, 6);
  endtask

  task automatic test_signed();
    mem[0] = 32'h0000_FFFE;
    mem[13'h200 >> 2] = 32'h0000_0003;
    run_dot("signed", 8'd1, 16'h0200, 13'h204, 32'hFFFF_FFFA, 16'h0001, 2);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      mem[i] = 32'h0000_7FFF;
      mem[(13'h300 >> 2) + i] = 32'h0000_7FFF;
    end
    run_dot("overflow", 8'd3, 16'h0300, 13'h30C, 32'hBFFD_0003, 16'h0005, 6);
  endtask

  task automatic test_len_zero();
    run_dot("len0", 8'd0, 16'h0040, 13'h040, 32'h0000_0000, 16'h0001, 0);
  endtask

  task automatic test_abort();
    int w0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'h1;
      mem[(13'h900 >> 2) + i] = 32'h1;
    end
    mem[13'h500 >> 2] = 32'h0000_FFFE;
    @(negedge clk);
    w0 = wr_cnt;
    ram_sel = 16'h0900;
    stat_reg_cal = 16'h0801;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (done_reg !== 16'h0002) begin n_err++; $display("FAIL abort_pre: got %h want 0002", done_reg); end
    stat_reg_cal = 16'h0803;
    @(negedge clk);
    n_cmp++;
    if (done_reg !== 16'h0000) begin n_err++; $display("FAIL abort_idle: got %h want 0000", done_reg); end
    stat_reg_cal = 16'h0000;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== w0 || done_reg !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_no_write: got writes %0d done_reg %h want 0 0000", wr_cnt - w0, done_reg);
    end
    run_dot("abort_rerun", 8'd1, 16'h0500, 13'h504, 32'hFFFF_FFFE, 16'h0001, 2);
  endtask

  task automatic test_robust();
    int w0;
    mem[0] = 32'h3; mem[1] = 32'h4;
    mem[13'h600 >> 2] = 32'h5; mem[(13'h600 >> 2) + 1] = 32'h6;
    @(negedge clk);
    w0 = wr_cnt;
    ram_sel = 16'h0600;
    stat_reg_cal = 16'h0201;
    @(negedge clk);
    stat_reg_cal = 16'h0200;
    ram_sel = 16'h0700;
    @(negedge clk);
    stat_reg_cal = 16'h0501;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL robust_wr_count: got %0d want 1", wr_cnt - w0); end
    n_cmp++;
    if (last_wr_addr !== 13'h608) begin n_err++; $display("FAIL robust_wr_addr: got %h want 0608", last_wr_addr); end
    n_cmp++;
    if (last_wr_data !== 32'h27) begin n_err++; $display("FAIL robust_wr_data: got %h want 00000027", last_wr_data); end
    n_cmp++;
    if (done_reg !== 16'h0001) begin n_err++; $display("FAIL robust_done: got %h want 0001", done_reg); end
    stat_reg_cal = 16'h0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w0;
    @(negedge clk);
    w0 = wr_cnt;
    ram_sel = 16'h0800;
    stat_reg_cal = 16'h0201;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seq_rd_en !== 1'b1 || seq_rd_addr !== 13'h800) begin
      n_err++;
      $display("FAIL rstmid_rd_b: got rd %b addr %h want 1 0800", seq_rd_en, seq_rd_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seq_rd_en !== 1'b0 || seq_rd_addr !== 13'h0 || seq_wr_en !== 1'b0 ||
        done_reg !== 16'h0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async: got rd %b addr %h wr %b done_reg %h result %h want all 0",
               seq_rd_en, seq_rd_addr, seq_wr_en, done_reg, result);
    end
    stat_reg_cal = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== w0 || done_reg !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_after: got writes %0d done_reg %h want 0 0000", wr_cnt - w0, done_reg);
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (viol !== 0) begin n_err++; $display("FAIL strobe_rules: got %0d bad cycles want 0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_len_zero();
    test_abort();
    test_robust();
    test_reset_mid();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accel_dot_seq.md
Name: accel_dot_seq

Overview:
- Compute sequencer directly downstream of the ICB register/SRAM slave.
- Consumes STAT_REG_CAL (start/abort/length) and RAM_SEL (operand-B base), and produces DONE_REG.
- On start, reads two signed 16-bit operand vectors from the shared accelerator SRAM, accumulates their dot product, writes the 32-bit result back to SRAM, then flags done.
- Owns a dedicated SRAM read/write port; bank arbitration sits outside this block.

Parameters:
- ADDR_W, 13, SRAM address width (byte-offset addressing, same as the slave).
- DATA_W, 32, SRAM word width.
- ADDR_STEP, 4, address increment between consecutive elements.
- A_BASE, 13'h000, fixed base address of vector A.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- stat_reg_cal  in  16  bit0=start (rising edge triggers), bit1=abort, [15:8]=len (elements).
- ram_sel  in  16  [12:0]=B base address; [15:13] ignored.
- done_reg  out  16  bit0=done (sticky), bit1=busy, bit2=overflow (sticky), others 0.
- seq_rd_en  out  1  SRAM read strobe.
- seq_rd_addr  out  ADDR_W  SRAM read address.
- seq_rd_data  in  DATA_W  SRAM read data, valid the cycle after seq_rd_en.
- seq_wr_en  out  1  SRAM write strobe.
- seq_wr_addr  out  ADDR_W  SRAM write address.
- seq_wr_data  out  DATA_W  SRAM write data.
- result  out  32  last accumulated result, held until next start.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset clears all state and outputs to 0 and forces IDLE.
- Reset mid-operation: abandons the run; no SRAM write occurs.
- Start detect: start_d registers stat_reg_cal[0]; start_pulse = stat_reg_cal[0] & ~start_d. A start_pulse while busy is ignored.
- Capture on start_pulse in IDLE:
  - len from stat_reg_cal[15:8].
  - b_base from ram_sel[12:0].
  - Clears acc, idx, done, overflow and result.
  - Later changes to the registers are ignored until the run finishes.
- FSM states: IDLE, RD_A, RD_B, MAC, WR, DONE.
  - IDLE -> RD_A on start_pulse when len!=0; IDLE -> WR when len==0 (writes 0).
  - RD_A: seq_rd_en=1, addr = A_BASE + idx*ADDR_STEP.
  - RD_B: seq_rd_en=1, addr = b_base + idx*ADDR_STEP; capture seq_rd_data[15:0] as a.
  - MAC: capture b = seq_rd_data[15:0]; acc <= acc + signed(a)*signed(b); idx++.
    - Go to RD_A if idx+1 < len, else WR.
  - WR: seq_wr_en=1 for exactly one cycle; addr = b_base + len*ADDR_STEP; data = acc; result <= acc.
  - DONE: done=1; immediately returns to IDLE (done stays sticky).
- Throughput and latency:
  - 3 cycles per element.
  - With stat_reg_cal[0] first sampled high at edge E0, busy is visible after E0.
  - The WR cycle is E0+3*len .. E0+3*len+1.
  - done=1 is visible after edge E0+3*len+1.
- Arithmetic:
  - Product is 32-bit signed (16x16).
  - acc is 32-bit two's complement and wraps.
  - overflow is set when the signs of both addends are equal and the sum's sign differs; it is sticky until the next start.
- Address arithmetic is modulo 2^ADDR_W (wrap-around permitted, no error).
- Strobe exclusivity: rd_en and wr_en are never high in the same cycle. When not asserted, rd/wr addr and data are driven to 0.
- Abort (stat_reg_cal[1]=1) in any busy state:
  - Next state IDLE, no write, done stays 0, busy clears.
  - Abort has priority over a same-cycle MAC/WR transition.
- A new start_pulse clears done in the same cycle busy rises.

Decomposition:
- Shared package accel_pkg:
  - state enum (IDLE..DONE).
  - STAT_REG bit-position constants (START_BIT, ABORT_BIT, LEN_LSB/MSB).
  - DONE_REG bit constants (DONE_BIT, BUSY_BIT, OVF_BIT).
  - ADDR_STEP default.
- One natural sub-module: accel_mac16, a signed 16x16 multiply plus 32-bit accumulate with overflow flag, clear and enable inputs.

Test Plan:
- Basic dot: A=[1,2,3] at 0,4,8; ram_sel=0x100, B=[4,5,6] at 0x100..0x108; stat_reg_cal=0x0301 -> write 32 (0x20) at 0x10C; done_reg=0x0001 after 3*3+1 edges; busy high throughout.
- Signed: len=1, A[0]=0xFFFE (-2), B[0]=3 -> wr_data=0xFFFFFFFA, overflow=0.
- Overflow: len=3, A and B all 0x7FFF -> acc wraps to 0xBFFD0003, done_reg=0x0005.
- len=0: stat_reg_cal=0x0001, ram_sel=0x40 -> single write of 0 at 0x40, no reads, done after 2 edges.
- Abort: start len=8, assert bit1 during the 2nd MAC -> no wr_en ever, done_reg=0x0000, then a new start with len=1 runs normally.
- Robustness: re-pulse start and change ram_sel while busy -> ignored, result address unchanged; assert rst_n=0 mid-RD_B -> all outputs 0 immediately (asynchronously), FSM in IDLE.
